// File: rtl/rf_pkg.sv
// Shared defaults and types for the register file with load scoreboard.
package rf_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 2;

    typedef logic signed [DATA_W_DEF-1:0] reg_t;
    typedef logic        [ADDR_W_DEF-1:0] raddr_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: tracks reserved loads, arbitrates port A/B writes, raises sticky protocol errors.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 0,
    parameter int NUM_REGS = 2**ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wa_en,
    input  logic [ADDR_W-1:0]   wa_addr,
    input  logic                wb_en,
    input  logic [ADDR_W-1:0]   wb_addr,
    input  logic                rsv_en,
    input  logic [ADDR_W-1:0]   rsv_addr,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic                wa_allow,
    output logic                wb_allow,
    output logic                wa_conflict,
    output logic                err
);
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [NUM_REGS-1:0] wb_hit, rsv_hit;
    logic                err_q, err_d;
    logic                wa_z, wb_z;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        // R0 is hard-wired when ZERO_REG is set: never hit, never busy
        localparam bit IS_Z = (ZERO_REG != 0) && (g == 0);
        assign wb_hit[g]  = !IS_Z && wb_en  && (wb_addr  == ADDR_W'(g));
        assign rsv_hit[g] = !IS_Z && rsv_en && (rsv_addr == ADDR_W'(g));
        // Reserve beats a same-edge load return (back-to-back load)
        assign busy_d[g]  = IS_Z       ? 1'b0 :
                            rsv_hit[g] ? 1'b1 :
                            wb_hit[g]  ? 1'b0 : busy_q[g];
    end

    assign wa_z        = (ZERO_REG != 0) && (wa_addr == '0);
    assign wb_z        = (ZERO_REG != 0) && (wb_addr == '0);
    assign wa_conflict = wa_en && busy_q[wa_addr];
    assign wa_allow    = wa_en && !busy_q[wa_addr] && !wa_z;
    assign wb_allow    = wb_en && !wb_z;

    assign err_d = err_q
                 | (|(wb_hit & ~busy_q))
                 | (|(rsv_hit & busy_q & ~wb_hit));

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign busy_vec = busy_q;
    assign err      = err_q;
endmodule

// File: rtl/reg_file_sb.sv
// Register file with two async read ports, ALU and load-return write ports, and a load scoreboard.
module reg_file_sb
    import rf_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 0,
    parameter int NUM_REGS = 2**ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic        [ADDR_W-1:0] ra,
    input  logic        [ADDR_W-1:0] rb,
    output logic signed [DATA_W-1:0] rd_data1,
    output logic signed [DATA_W-1:0] rd_data2,
    input  logic                     wa_en,
    input  logic        [ADDR_W-1:0] wa_addr,
    input  logic signed [DATA_W-1:0] wa_data,
    input  logic                     wb_en,
    input  logic        [ADDR_W-1:0] wb_addr,
    input  logic signed [DATA_W-1:0] wb_data,
    input  logic                     rsv_en,
    input  logic        [ADDR_W-1:0] rsv_addr,
    output logic                     busy1,
    output logic                     busy2,
    output logic                     wa_conflict,
    output logic [NUM_REGS-1:0]      busy_vec,
    output logic                     err
);
    logic signed [DATA_W-1:0] regs_q [NUM_REGS];
    logic                     wa_allow, wb_allow;

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .NUM_REGS (NUM_REGS)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .wa_en       (wa_en),
        .wa_addr     (wa_addr),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .rsv_en      (rsv_en),
        .rsv_addr    (rsv_addr),
        .busy_vec    (busy_vec),
        .wa_allow    (wa_allow),
        .wb_allow    (wb_allow),
        .wa_conflict (wa_conflict),
        .err         (err)
    );

    // Falling-edge writes make data visible for the following rising edge, so no bypass
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            if (wa_allow) regs_q[wa_addr] <= wa_data;
            if (wb_allow) regs_q[wb_addr] <= wb_data;
        end
    end

    assign rd_data1 = ((ZERO_REG != 0) && (ra == '0)) ? '0 : regs_q[ra];
    assign rd_data2 = ((ZERO_REG != 0) && (rb == '0)) ? '0 : regs_q[rb];
    assign busy1    = busy_vec[ra];
    assign busy2    = busy_vec[rb];
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: default instance plus a ZERO_REG=1 instance sharing stimulus.
module tb_reg_file_sb;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] ra = '0, rb = '0, wa_addr = '0, wb_addr = '0, rsv_addr = '0;
    logic [7:0] wa_data = '0, wb_data = '0;
    logic       wa_en = 1'b0, wb_en = 1'b0, rsv_en = 1'b0;

    logic [7:0] rd1, rd2, z_rd1, z_rd2;
    logic       busy1, busy2, wac, err;
    logic       z_busy1, z_busy2, z_wac, z_err;
    logic [3:0] bv, z_bv;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    reg_file_sb #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(0)) u_dut (
        .clk(clk), .rst(rst), .ra(ra), .rb(rb), .rd_data1(rd1), .rd_data2(rd2),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy1(busy1), .busy2(busy2),
        .wa_conflict(wac), .busy_vec(bv), .err(err)
    );

    reg_file_sb #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(1)) u_dut_z (
        .clk(clk), .rst(rst), .ra(ra), .rb(rb), .rd_data1(z_rd1), .rd_data2(z_rd2),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy1(z_busy1), .busy2(z_busy2),
        .wa_conflict(z_wac), .busy_vec(z_bv), .err(z_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply on the falling edge, then settle
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        wa_en = 1'b0; wb_en = 1'b0; rsv_en = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_rd1", 32'(rd1), 32'h0);
        check("rst_bv",  32'(bv),  32'h0);
        check("rst_err", 32'(err), 32'h0);
        tick();
        rst = 1'b1;
    endtask

    initial begin
        #1 rst = 1'b0;
        #1;
        check("t1_rd1", 32'(rd1), 32'h0);
        check("t1_rd2", 32'(rd2), 32'h0);
        check("t1_bv",  32'(bv),  32'h0);
        check("t1_err", 32'(err), 32'h0);
        tick();
        rst = 1'b1;

        // ALU write of -5 to R2
        wa_en = 1'b1; wa_addr = 2'd2; wa_data = 8'hFB;
        tick(); idle();
        ra = 2'd2; rb = 2'd2; #1;
        check("t2_rd1", 32'(rd1), 32'hFB);
        check("t2_rd2", 32'(rd2), 32'hFB);

        // Load flow on R1
        rsv_en = 1'b1; rsv_addr = 2'd1;
        tick(); idle();
        check("t3_bv_set", 32'(bv), 32'b0010);
        ra = 2'd1; #1;
        check("t3_busy1", 32'(busy1), 32'h1);
        check("t3_busy2", 32'(busy2), 32'h0);
        tick(); tick(); tick();
        wb_en = 1'b1; wb_addr = 2'd1; wb_data = 8'h3C;
        tick(); idle();
        check("t3_r1",    32'(rd1), 32'h3C);
        check("t3_bv_clr", 32'(bv), 32'h0);
        check("t3_err",   32'(err), 32'h0);

        // WAW block on R3
        rsv_en = 1'b1; rsv_addr = 2'd3;
        tick(); idle();
        ra = 2'd3;
        wa_en = 1'b1; wa_addr = 2'd3; wa_data = 8'h11; #1;
        check("t4_conf", 32'(wac), 32'h1);
        tick(); idle();
        check("t4_r3_kept", 32'(rd1), 32'h0);
        check("t4_bv",      32'(bv),  32'b1000);
        wa_en = 1'b1; wa_addr = 2'd3; wa_data = 8'h11;
        wb_en = 1'b1; wb_addr = 2'd3; wb_data = 8'h22; #1;
        check("t4_conf2", 32'(wac), 32'h1);
        tick(); idle(); #1;
        check("t4_r3_wb", 32'(rd1), 32'h22);
        check("t4_bv2",   32'(bv),  32'h0);
        check("t4_noconf", 32'(wac), 32'h0);

        // rsv + wb same register: data written, busy stays set, no err
        rsv_en = 1'b1; rsv_addr = 2'd1;
        tick();
        wb_en = 1'b1; wb_addr = 2'd1; wb_data = 8'h55;
        tick(); idle();
        ra = 2'd1; #1;
        check("rw_r1",  32'(rd1), 32'h55);
        check("rw_bv",  32'(bv),  32'b0010);
        check("rw_err", 32'(err), 32'h0);
        wb_en = 1'b1; wb_addr = 2'd1; wb_data = 8'h66;
        tick(); idle();

        // wa + rsv same non-busy register: write lands, then busy
        wa_en = 1'b1; wa_addr = 2'd0; wa_data = 8'h0A;
        rsv_en = 1'b1; rsv_addr = 2'd0;
        tick(); idle();
        ra = 2'd0; #1;
        check("wr_r0", 32'(rd1), 32'h0A);
        check("wr_bv", 32'(bv),  32'b0001);
        wb_en = 1'b1; wb_addr = 2'd0; wb_data = 8'h0B;
        tick(); idle();
        check("wr_r0b", 32'(rd1), 32'h0B);

        // Independent ops on different addresses in one edge
        rsv_en = 1'b1; rsv_addr = 2'd2;
        wa_en = 1'b1; wa_addr = 2'd3; wa_data = 8'h33;
        tick(); idle();
        ra = 2'd3; #1;
        check("ind_r3", 32'(rd1), 32'h33);
        check("ind_bv", 32'(bv),  32'b0100);
        wb_en = 1'b1; wb_addr = 2'd2; wb_data = 8'h44;
        rsv_en = 1'b1; rsv_addr = 2'd1;
        wa_en = 1'b1; wa_addr = 2'd0; wa_data = 8'h01;
        tick(); idle();
        ra = 2'd2; rb = 2'd0; #1;
        check("ind_r2",  32'(rd1), 32'h44);
        check("ind_r0",  32'(rd2), 32'h01);
        check("ind_bv2", 32'(bv),  32'b0010);
        check("ind_err", 32'(err), 32'h0);
        wb_en = 1'b1; wb_addr = 2'd1; wb_data = 8'h10;
        tick(); idle();
        check("pre5_err", 32'(err), 32'h0);

        // Load return to a non-busy register
        wb_en = 1'b1; wb_addr = 2'd2; wb_data = 8'h77;
        tick(); idle();
        check("t5_err", 32'(err), 32'h1);
        check("t5_r2",  32'(rd1), 32'h77);
        wa_en = 1'b1; wa_addr = 2'd3; wa_data = 8'h12;
        tick(); idle();
        ra = 2'd3; #1;
        check("t5_sticky", 32'(err), 32'h1);
        check("t5_r3",     32'(rd1), 32'h12);
        do_reset();
        check("t5_cleared", 32'(err), 32'h0);

        // Reserve of an already-busy register
        rsv_en = 1'b1; rsv_addr = 2'd1;
        tick();
        check("dbl_err0", 32'(err), 32'h0);
        tick(); idle();
        check("dbl_err1", 32'(err), 32'h1);
        do_reset();

        // Reset between reserve and load return
        rsv_en = 1'b1; rsv_addr = 2'd2;
        tick(); idle();
        check("mid_bv", 32'(bv), 32'b0100);
        do_reset();
        wb_en = 1'b1; wb_addr = 2'd2; wb_data = 8'h5A;
        tick(); idle();
        check("mid_err", 32'(err), 32'h1);
        do_reset();

        // ZERO_REG instance: R0 stays 0 and never busy
        wa_en = 1'b1; wa_addr = 2'd0; wa_data = 8'h7F;
        tick(); idle();
        rsv_en = 1'b1; rsv_addr = 2'd0;
        tick(); idle();
        ra = 2'd0; #1;
        check("t6_rd1",  32'(z_rd1),   32'h0);
        check("t6_bv0",  32'(z_bv[0]), 32'h0);
        check("t6_err",  32'(z_err),   32'h0);
        check("t6_ref",  32'(rd1),     32'h7F);
        wa_en = 1'b1; wa_addr = 2'd1; wa_data = 8'h81;
        tick(); idle();
        ra = 2'd1; #1;
        check("t6_r1", 32'(z_rd1), 32'h81);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
